// File: rtl/dsec_pkg.sv
// Shared types and sizing for the DSEC block packer: FSM states and block geometry.
package dsec_pkg;

  localparam int BLK_W         = 64;
  localparam int BYTE_W        = 8;
  localparam int BYTES_PER_BLK = 8;
  localparam int KEY_BLKS      = 3;
  localparam int CNT_W         = $clog2(BYTES_PER_BLK);
  localparam int KEY_CNT_W     = $clog2(KEY_BLKS);

  typedef enum logic [1:0] {
    ST_FILL = 2'd0,
    ST_WAIT = 2'd1,
    ST_SEND = 2'd2,
    ST_ERR  = 2'd3
  } state_t;

  // Zero bytes left in a block whose last accepted byte sat at lane idx.
  function automatic logic [CNT_W-1:0] pad_count(input logic [CNT_W-1:0] idx);
    return CNT_W'(BYTES_PER_BLK - 1) - idx;
  endfunction

endpackage

// File: rtl/dsec_block_packer.sv
// Packs an upstream byte stream into 64-bit big-endian blocks for the DSEC core,
// sequencing 3-block key sets ahead of data and latching any protocol violation.
module dsec_block_packer
  import dsec_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic [7:0]       s_data,
  input  logic             s_valid,
  output logic             s_ready,
  input  logic             s_key,
  input  logic             s_last,
  output logic [BLK_W-1:0] m_data,
  output logic             m_valid,
  output logic             m_key_config,
  input  logic             m_rdy,
  output logic [2:0]       pad_bytes,
  output logic             msg_done,
  output logic             err
);

  state_t                 state_reg;
  logic [BLK_W-1:0]       acc_reg;
  logic [BLK_W-1:0]       acc_next;
  logic [CNT_W-1:0]       byte_cnt_reg;
  logic [KEY_CNT_W-1:0]   key_cnt_reg;
  logic                   keys_loaded_reg;
  logic                   blk_key_reg;
  logic                   blk_last_reg;
  logic [BLK_W-1:0]       m_data_reg;
  logic                   m_valid_reg;
  logic                   m_key_config_reg;
  logic [2:0]             pad_bytes_reg;
  logic                   msg_done_reg;
  logic                   err_reg;

  logic accept;
  logic first_byte;
  logic type_mismatch;
  logic key_last;
  logic data_too_early;
  logic proto_err;
  logic closing;

  assign s_ready      = (state_reg == ST_FILL);
  assign m_data       = m_data_reg;
  assign m_valid      = m_valid_reg;
  assign m_key_config = m_key_config_reg;
  assign pad_bytes    = pad_bytes_reg;
  assign msg_done     = msg_done_reg;
  assign err          = err_reg;

  assign accept     = s_valid && (state_reg == ST_FILL);
  assign first_byte = (byte_cnt_reg == '0);

  // Protocol checks applied to the byte on the accepting edge.
  assign type_mismatch  = !first_byte && (s_key != blk_key_reg);
  assign key_last       = s_key && s_last;
  assign data_too_early = first_byte && !s_key &&
                          ((key_cnt_reg != '0) || !keys_loaded_reg);
  assign proto_err      = accept && (type_mismatch || key_last || data_too_early);

  assign closing = accept && !proto_err &&
                   ((byte_cnt_reg == CNT_W'(BYTES_PER_BLK - 1)) || s_last);

  // Lane gi takes the incoming byte when it is the next free lane; first byte lands in the MSB lane.
  genvar gi;
  generate
    for (gi = 0; gi < BYTES_PER_BLK; gi++) begin : g_lane
      assign acc_next[BLK_W-1-gi*BYTE_W -: BYTE_W] =
        (byte_cnt_reg == CNT_W'(gi)) ? s_data : acc_reg[BLK_W-1-gi*BYTE_W -: BYTE_W];
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg        <= ST_FILL;
      acc_reg          <= '0;
      byte_cnt_reg     <= '0;
      key_cnt_reg      <= '0;
      keys_loaded_reg  <= 1'b0;
      blk_key_reg      <= 1'b0;
      blk_last_reg     <= 1'b0;
      m_data_reg       <= '0;
      m_valid_reg      <= 1'b0;
      m_key_config_reg <= 1'b0;
      pad_bytes_reg    <= '0;
      msg_done_reg     <= 1'b0;
      err_reg          <= 1'b0;
    end else begin
      m_valid_reg  <= 1'b0;
      msg_done_reg <= 1'b0;
      case (state_reg)
        ST_FILL: begin
          if (proto_err) begin
            state_reg        <= ST_ERR;
            err_reg          <= 1'b1;
            m_key_config_reg <= 1'b0;
            acc_reg          <= '0;
          end else if (accept) begin
            if (first_byte) begin
              blk_key_reg <= s_key;
            end
            if (closing) begin
              // Unused low lanes of acc_reg are already zero, so padding is free.
              state_reg     <= ST_WAIT;
              m_data_reg    <= acc_next;
              acc_reg       <= '0;
              byte_cnt_reg  <= '0;
              blk_last_reg  <= s_last;
              pad_bytes_reg <= pad_count(byte_cnt_reg);
              if (first_byte ? s_key : blk_key_reg) begin
                m_key_config_reg <= 1'b1;
              end
            end else begin
              acc_reg      <= acc_next;
              byte_cnt_reg <= byte_cnt_reg + 1'b1;
            end
          end
        end
        ST_WAIT: begin
          if (m_rdy) begin
            state_reg    <= ST_SEND;
            m_valid_reg  <= 1'b1;
            msg_done_reg <= blk_last_reg;
          end
        end
        ST_SEND: begin
          state_reg     <= ST_FILL;
          pad_bytes_reg <= '0;
          blk_last_reg  <= 1'b0;
          if (blk_key_reg) begin
            if (key_cnt_reg == KEY_CNT_W'(KEY_BLKS - 1)) begin
              key_cnt_reg      <= '0;
              keys_loaded_reg  <= 1'b1;
              m_key_config_reg <= 1'b0;
            end else begin
              key_cnt_reg <= key_cnt_reg + 1'b1;
            end
          end
        end
        default: begin
          // Error is terminal until reset.
          state_reg        <= ST_ERR;
          err_reg          <= 1'b1;
          m_key_config_reg <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_dsec_block_packer.sv
// Directed bench for dsec_block_packer: drives byte streams, scoreboards emitted blocks.
module tb_dsec_block_packer;

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  s_data;
  logic        s_valid;
  logic        s_ready;
  logic        s_key;
  logic        s_last;
  logic [63:0] m_data;
  logic        m_valid;
  logic        m_key_config;
  logic        m_rdy;
  logic [2:0]  pad_bytes;
  logic        msg_done;
  logic        err;

  typedef struct packed {
    logic [63:0] data;
    logic [2:0]  pad;
    logic        done;
    logic        kc;
  } exp_t;

  exp_t sb_q[$];
  int   total = 0;
  int   bad   = 0;

  logic [63:0] k0 = 64'h9474B8E8C73BCA7D;
  logic [63:0] k1 = 64'h8DA744E0C94E5E17;
  logic [63:0] k2 = 64'h0CDB25E3BA3C6D79;
  logic [63:0] d0 = 64'h9474B8E8C73BCA7D;
  logic [63:0] p0 = 64'h0CDB25E3BA3C6D79;
  logic [63:0] d1 = 64'h0123456789ABCDEF;
  logic [63:0] p1 = 64'hAB11223344556677;
  logic [63:0] junk = 64'hDEADBEEFCAFEF00D;

  dsec_block_packer dut (
    .clk          (clk),
    .rst          (rst),
    .s_data       (s_data),
    .s_valid      (s_valid),
    .s_ready      (s_ready),
    .s_key        (s_key),
    .s_last       (s_last),
    .m_data       (m_data),
    .m_valid      (m_valid),
    .m_key_config (m_key_config),
    .m_rdy        (m_rdy),
    .pad_bytes    (pad_bytes),
    .msg_done     (msg_done),
    .err          (err)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  // Scoreboard side: every m_valid pulse must match the oldest expected block.
  always @(negedge clk) begin
    if (!rst && m_valid) begin
      exp_t e;
      check("sb_nonempty", 64'(sb_q.size() != 0), 64'd1);
      if (sb_q.size() != 0) begin
        e = sb_q.pop_front();
        check("blk_data", m_data, e.data);
        check("blk_pad", 64'(pad_bytes), 64'(e.pad));
        check("blk_done", 64'(msg_done), 64'(e.done));
        check("blk_keycfg", 64'(m_key_config), 64'(e.kc));
        $display("block data=%h pad=%0d done=%0b keycfg=%0b", m_data, pad_bytes, msg_done, m_key_config);
      end
    end
  end

  task automatic send_byte(input logic [7:0] d, input logic k, input logic l);
    int waitc;
    waitc   = 0;
    s_data  = d;
    s_key   = k;
    s_last  = l;
    s_valid = 1'b1;
    while (!s_ready && waitc < 100) begin
      @(negedge clk);
      waitc++;
    end
    check("ready_wait", 64'(waitc < 100), 64'd1);
    @(posedge clk);
    #1;
    s_valid = 1'b0;
    s_key   = 1'b0;
    s_last  = 1'b0;
  endtask

  // Sends the first n bytes of blk; pushes the expected padded block first when push is set.
  task automatic send_block(input logic [63:0] blk, input int n, input logic k,
                            input logic last, input logic kc, input logic push);
    logic [63:0] e;
    logic [7:0]  b;
    exp_t        x;
    e = '0;
    for (int j = 0; j < n; j++) e[63-8*j -: 8] = blk[63-8*j -: 8];
    x.data = e;
    x.pad  = 3'(8 - n);
    x.done = last;
    x.kc   = kc;
    if (push) sb_q.push_back(x);
    for (int i = 0; i < n; i++) begin
      b = blk[63-8*i -: 8];
      send_byte(b, k, last && (i == n - 1));
    end
  endtask

  task automatic check_reset_state(input string tag);
    check({tag, "_m_valid"}, 64'(m_valid), 64'd0);
    check({tag, "_keycfg"}, 64'(m_key_config), 64'd0);
    check({tag, "_err"}, 64'(err), 64'd0);
    check({tag, "_pad"}, 64'(pad_bytes), 64'd0);
    check({tag, "_m_data"}, m_data, 64'd0);
    check({tag, "_done"}, 64'(msg_done), 64'd0);
    check({tag, "_s_ready"}, 64'(s_ready), 64'd1);
  endtask

  task automatic pulse_reset();
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1; s_data = '0; s_valid = 1'b0; s_key = 1'b0; s_last = 1'b0; m_rdy = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_reset_state("reset");
    rst = 1'b0;
    @(negedge clk);
    check("post_reset_ready", 64'(s_ready), 64'd1);

    // Key set then a full data block closed by s_last.
    send_block(k0, 8, 1'b1, 1'b0, 1'b1, 1'b1);
    send_block(k1, 8, 1'b1, 1'b0, 1'b1, 1'b1);
    send_block(k2, 8, 1'b1, 1'b0, 1'b1, 1'b1);
    send_block(d0, 8, 1'b0, 1'b1, 1'b0, 1'b1);

    // Partial block and minimum latency.
    send_block(p0, 3, 1'b0, 1'b1, 1'b0, 1'b1);
    @(negedge clk);
    check("lat_wait_valid", 64'(m_valid), 64'd0);
    check("lat_wait_pad", 64'(pad_bytes), 64'd5);
    check("lat_wait_ready", 64'(s_ready), 64'd0);
    @(negedge clk);
    check("lat_send_valid", 64'(m_valid), 64'd1);

    // Backpressure: WAIT held for 10 cycles.
    m_rdy = 1'b0;
    send_block(d1, 8, 1'b0, 1'b0, 1'b0, 1'b1);
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      check("bp_ready", 64'(s_ready), 64'd0);
      check("bp_data", m_data, d1);
      check("bp_valid", 64'(m_valid), 64'd0);
    end
    m_rdy = 1'b1;
    @(negedge clk);
    check("bp_release_valid", 64'(m_valid), 64'd1);

    // Second key set after data, then more data.
    send_block(k2, 8, 1'b1, 1'b0, 1'b1, 1'b1);
    send_block(k0, 8, 1'b1, 1'b0, 1'b1, 1'b1);
    send_block(k1, 8, 1'b1, 1'b0, 1'b1, 1'b1);
    send_block(p1, 1, 1'b0, 1'b1, 1'b0, 1'b1);
    repeat (4) @(negedge clk);
    check("keycfg_after_set", 64'(m_key_config), 64'd0);

    // Data byte after only two key blocks.
    pulse_reset();
    send_block(k0, 8, 1'b1, 1'b0, 1'b1, 1'b1);
    send_block(k1, 8, 1'b1, 1'b0, 1'b1, 1'b1);
    @(negedge clk);
    check("keycfg_mid_set", 64'(m_key_config), 64'd1);
    send_byte(8'h55, 1'b0, 1'b0);
    check("err_next_cycle", 64'(err), 64'd1);
    @(negedge clk);
    check("err_ready", 64'(s_ready), 64'd0);
    check("err_keycfg", 64'(m_key_config), 64'd0);
    repeat (5) @(negedge clk);
    check("err_sticky", 64'(err), 64'd1);
    check("err_sticky_ready", 64'(s_ready), 64'd0);
    check("err_no_valid", 64'(m_valid), 64'd0);
    check("err_sb_empty", 64'(sb_q.size()), 64'd0);

    // Recovery, with a reset landing mid key block.
    pulse_reset();
    check_reset_state("rst_after_err");
    send_block(junk, 3, 1'b1, 1'b0, 1'b1, 1'b0);
    pulse_reset();
    check("midblk_rst_ready", 64'(s_ready), 64'd1);
    send_block(k0, 8, 1'b1, 1'b0, 1'b1, 1'b1);
    send_block(k1, 8, 1'b1, 1'b0, 1'b1, 1'b1);
    send_block(k2, 8, 1'b1, 1'b0, 1'b1, 1'b1);
    send_block(d0, 8, 1'b0, 1'b1, 1'b0, 1'b1);

    // s_last on a key byte is illegal.
    send_byte(8'h11, 1'b1, 1'b1);
    check("keylast_err", 64'(err), 64'd1);
    check("keylast_ready", 64'(s_ready), 64'd0);

    repeat (4) @(negedge clk);
    check("final_sb_empty", 64'(sb_q.size()), 64'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
